// File: rtl/down_seq_pkg.sv
// rtl/down_seq_pkg.sv - shared state encoding, default widths and pass-length helper
package down_seq_pkg;

  localparam int DEF_WIDTH = 4;
  localparam int DEF_RPT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_PAUSED = 2'd2,
    ST_DONE   = 2'd3
  } seq_state_e;

  // Cycles spent in one pass from load down to term, wrapping modulo 2^width.
  function automatic int pass_len(input int load, input int term, input int width);
    return ((load - term) & ((1 << width) - 1)) + 1;
  endfunction

endpackage

// File: rtl/down_count_core.sv
// rtl/down_count_core.sv - loadable modulo-2^WIDTH down counter with terminal compare
module down_count_core
  import down_seq_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_en,
  input  logic             dec_en,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] term,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_bar,
  output logic             at_term
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load_en) begin
      count_d = load_val;
    end else if (dec_en) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign q       = count_q;
  assign q_bar   = ~count_q;
  assign at_term = (count_q == term);

endmodule

// File: rtl/down_counter_sequencer.sv
// rtl/down_counter_sequencer.sv - command-driven sequencer for pausable, abortable count passes
module down_counter_sequencer
  import down_seq_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int RPT_W = DEF_RPT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [WIDTH-1:0] cmd_load,
  input  logic [WIDTH-1:0] cmd_term,
  input  logic             cmd_reload,
  input  logic [RPT_W-1:0] cmd_repeat,
  input  logic             pause,
  input  logic             abort,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_bar,
  output logic             busy,
  output logic             tc,
  output logic             done,
  output logic [RPT_W-1:0] passes_left
);

  seq_state_e       state_q, state_d;
  logic [WIDTH-1:0] load_q, load_d;
  logic [WIDTH-1:0] term_q, term_d;
  logic             reload_q, reload_d;
  logic [RPT_W-1:0] passes_q, passes_d;

  logic             core_load;
  logic             core_dec;
  logic [WIDTH-1:0] core_load_val;
  logic             at_term;

  down_count_core #(.WIDTH(WIDTH)) u_core (
    .clk      (clk),
    .reset    (reset),
    .load_en  (core_load),
    .dec_en   (core_dec),
    .load_val (core_load_val),
    .term     (term_q),
    .q        (q),
    .q_bar    (q_bar),
    .at_term  (at_term)
  );

  always_comb begin
    state_d       = state_q;
    load_d        = load_q;
    term_d        = term_q;
    reload_d      = reload_q;
    passes_d      = passes_q;
    core_load     = 1'b0;
    core_dec      = 1'b0;
    core_load_val = load_q;
    case (state_q)
      ST_IDLE: begin
        // abort has no meaning here, so a command arriving with it is still taken
        if (cmd_valid) begin
          load_d        = cmd_load;
          term_d        = cmd_term;
          reload_d      = cmd_reload;
          passes_d      = cmd_reload ? cmd_repeat : '0;
          core_load     = 1'b1;
          core_load_val = cmd_load;
          state_d       = ST_RUN;
        end
      end
      ST_RUN: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (pause) begin
          state_d = ST_PAUSED;
        end else if (at_term) begin
          if (reload_q && (passes_q != '0)) begin
            core_load = 1'b1;
            passes_d  = passes_q - 1'b1;
          end else begin
            state_d = ST_DONE;
          end
        end else begin
          core_dec = 1'b1;
        end
      end
      ST_PAUSED: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (!pause) begin
          state_d = ST_RUN;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      load_q   <= '0;
      term_q   <= '0;
      reload_q <= 1'b0;
      passes_q <= '0;
    end else begin
      state_q  <= state_d;
      load_q   <= load_d;
      term_q   <= term_d;
      reload_q <= reload_d;
      passes_q <= passes_d;
    end
  end

  assign cmd_ready   = (state_q == ST_IDLE);
  assign busy        = (state_q == ST_RUN) || (state_q == ST_PAUSED);
  assign tc          = (state_q == ST_RUN) && at_term && !pause && !abort;
  assign done        = (state_q == ST_DONE) && !abort;
  assign passes_left = passes_q;

endmodule

// File: tb/tb_down_counter_sequencer.sv
// tb/tb_down_counter_sequencer.sv - self-checking bench for down_counter_sequencer
module tb_down_counter_sequencer;
  import down_seq_pkg::*;

  logic       clk;
  logic       reset;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [3:0] cmd_load;
  logic [3:0] cmd_term;
  logic       cmd_reload;
  logic [3:0] cmd_repeat;
  logic       pause;
  logic       abort;
  logic [3:0] q;
  logic [3:0] q_bar;
  logic       busy;
  logic       tc;
  logic       done;
  logic [3:0] passes_left;

  int n_checks = 0;
  int n_fail   = 0;

  down_counter_sequencer #(.WIDTH(4), .RPT_W(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_load    (cmd_load),
    .cmd_term    (cmd_term),
    .cmd_reload  (cmd_reload),
    .cmd_repeat  (cmd_repeat),
    .pause       (pause),
    .abort       (abort),
    .q           (q),
    .q_bar       (q_bar),
    .busy        (busy),
    .tc          (tc),
    .done        (done),
    .passes_left (passes_left)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    #1;
    n_checks++;
    if (q !== 4'h0) begin n_fail++; $display("FAIL reset_q actual=%h required=0", q); end
    n_checks++;
    if (q_bar !== 4'hF) begin n_fail++; $display("FAIL reset_q_bar actual=%h required=f", q_bar); end
    n_checks++;
    if ({cmd_ready, busy, tc, done} !== 4'b1000) begin
      n_fail++; $display("FAIL reset_flags {ready,busy,tc,done} actual=%b required=1000", {cmd_ready, busy, tc, done});
    end
    n_checks++;
    if (passes_left !== 4'h0) begin n_fail++; $display("FAIL reset_passes actual=%h required=0", passes_left); end
  endtask

  task automatic test_passes();
    int d_ld[4] = '{5, 1, 3, 6};
    int d_tm[4] = '{2, 14, 1, 6};
    int d_rl[4] = '{0, 0, 1, 1};
    int d_rp[4] = '{0, 0, 2, 3};
    int ld, tm, rl, rp, len, npass;
    logic [3:0] eq;
    for (int k = 0; k < 24; k++) begin
      if (k < 4) begin
        ld = d_ld[k]; tm = d_tm[k]; rl = d_rl[k]; rp = d_rp[k];
      end else begin
        ld = int'($urandom_range(0, 15));
        tm = int'($urandom_range(0, 15));
        rl = int'($urandom_range(0, 1));
        rp = int'($urandom_range(0, 15));
      end
      npass = (rl != 0) ? rp + 1 : 1;
      len   = pass_len(ld, tm, 4);
      cmd_valid  = 1'b1;
      cmd_load   = 4'(ld);
      cmd_term   = 4'(tm);
      cmd_reload = rl[0];
      cmd_repeat = 4'(rp);
      #1;
      n_checks++;
      if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL pass_accept_ready cmd=%0d actual=%b required=1", k, cmd_ready); end
      tick();
      // Scrambled command inputs after accept must not disturb the run.
      cmd_valid  = 1'b0;
      cmd_load   = 4'($urandom);
      cmd_term   = 4'($urandom);
      cmd_reload = 1'($urandom);
      cmd_repeat = 4'($urandom);
      for (int p = 0; p < npass; p++) begin
        for (int i = 0; i < len; i++) begin
          eq = 4'(ld - i);
          #1;
          n_checks++;
          if (q !== eq || q_bar !== ~eq) begin
            n_fail++; $display("FAIL pass_q cmd=%0d pass=%0d step=%0d actual=%h/%h required=%h/%h", k, p, i, q, q_bar, eq, ~eq);
          end
          n_checks++;
          if (tc !== (i == len - 1)) begin
            n_fail++; $display("FAIL pass_tc cmd=%0d pass=%0d step=%0d actual=%b required=%b", k, p, i, tc, (i == len - 1));
          end
          n_checks++;
          if ({busy, done, cmd_ready} !== 3'b100) begin
            n_fail++; $display("FAIL pass_flags cmd=%0d {busy,done,ready} actual=%b required=100", k, {busy, done, cmd_ready});
          end
          n_checks++;
          if (passes_left !== ((rl != 0) ? 4'(rp - p) : 4'h0)) begin
            n_fail++; $display("FAIL pass_left cmd=%0d pass=%0d actual=%0d required=%0d", k, p, passes_left, (rl != 0) ? rp - p : 0);
          end
          tick();
        end
      end
      #1;
      n_checks++;
      if ({busy, done, cmd_ready, tc} !== 4'b0100 || q !== 4'(tm) || passes_left !== 4'h0) begin
        n_fail++; $display("FAIL pass_done cmd=%0d {busy,done,ready,tc} q left actual=%b %h %h required=0100 %h 0", k, {busy, done, cmd_ready, tc}, q, passes_left, 4'(tm));
      end
      tick();
      #1;
      n_checks++;
      if ({cmd_ready, done, busy} !== 3'b100 || q !== 4'(tm)) begin
        n_fail++; $display("FAIL pass_idle cmd=%0d {ready,done,busy} q actual=%b %h required=100 %h", k, {cmd_ready, done, busy}, q, 4'(tm));
      end
    end
  endtask

  task automatic test_pause_abort();
    logic [3:0] exp_q[10] = '{4'h9, 4'h9, 4'h8, 4'h7, 4'h6, 4'h6, 4'h6, 4'h6, 4'h5, 4'h4};
    cmd_valid = 1'b1; cmd_load = 4'h9; cmd_term = 4'h0; cmd_reload = 1'b0; cmd_repeat = 4'h0;
    tick();
    cmd_valid = 1'b0;
    for (int c = 1; c <= 9; c++) begin
      pause = (c == 4 || c == 5);
      abort = (c == 9);
      #1;
      n_checks++;
      if (q !== exp_q[c] || busy !== 1'b1 || tc !== 1'b0 || done !== 1'b0) begin
        n_fail++; $display("FAIL pause_cycle c=%0d q busy tc done actual=%h %b %b %b required=%h 1 0 0", c, q, busy, tc, done, exp_q[c]);
      end
      tick();
    end
    pause = 1'b0;
    abort = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      n_checks++;
      if (q !== 4'h4 || {cmd_ready, busy, done, tc} !== 4'b1000) begin
        n_fail++; $display("FAIL abort_idle c=%0d q {ready,busy,done,tc} actual=%h %b required=4 1000", c, q, {cmd_ready, busy, done, tc});
      end
      tick();
    end
  endtask

  task automatic test_busy_handshake();
    logic [3:0] exp_q[4] = '{4'h3, 4'h3, 4'h2, 4'h1};
    cmd_valid = 1'b1; cmd_load = 4'h3; cmd_term = 4'h1; cmd_reload = 1'b0; cmd_repeat = 4'h0;
    tick();
    cmd_load = 4'h7; cmd_term = 4'h5; cmd_reload = 1'b1; cmd_repeat = 4'h4;
    for (int c = 1; c <= 3; c++) begin
      #1;
      n_checks++;
      if (cmd_ready !== 1'b0 || q !== exp_q[c] || passes_left !== 4'h0) begin
        n_fail++; $display("FAIL busy_run c=%0d ready q left actual=%b %h %h required=0 %h 0", c, cmd_ready, q, passes_left, exp_q[c]);
      end
      tick();
    end
    #1;
    n_checks++;
    if (done !== 1'b1 || cmd_ready !== 1'b0) begin
      n_fail++; $display("FAIL busy_done done ready actual=%b %b required=1 0", done, cmd_ready);
    end
    tick();
    #1;
    n_checks++;
    if (cmd_ready !== 1'b1 || q !== 4'h1) begin
      n_fail++; $display("FAIL busy_accept ready q actual=%b %h required=1 1", cmd_ready, q);
    end
    tick();
    cmd_valid = 1'b0;
    abort = 1'b1;
    #1;
    n_checks++;
    if (q !== 4'h7 || busy !== 1'b1 || passes_left !== 4'h4) begin
      n_fail++; $display("FAIL busy_new_cmd q busy left actual=%h %b %h required=7 1 4", q, busy, passes_left);
    end
    tick();
    // abort is ignored in IDLE, so a command presented with it must still start.
    cmd_valid = 1'b1; cmd_load = 4'hA; cmd_reload = 1'b0;
    #1;
    n_checks++;
    if (cmd_ready !== 1'b1 || q !== 4'h7 || passes_left !== 4'h4) begin
      n_fail++; $display("FAIL abort_hold ready q left actual=%b %h %h required=1 7 4", cmd_ready, q, passes_left);
    end
    tick();
    cmd_valid = 1'b0;
    #1;
    n_checks++;
    if (q !== 4'hA || busy !== 1'b1 || done !== 1'b0) begin
      n_fail++; $display("FAIL idle_abort_accept q busy done actual=%h %b %b required=a 1 0", q, busy, done);
    end
    tick();
    abort = 1'b0;
    #1;
    n_checks++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
      n_fail++; $display("FAIL abort_to_idle ready busy actual=%b %b required=1 0", cmd_ready, busy);
    end
  endtask

  task automatic test_reset_mid_run();
    cmd_valid = 1'b1; cmd_load = 4'h5; cmd_term = 4'h0; cmd_reload = 1'b1; cmd_repeat = 4'h3;
    tick();
    cmd_valid = 1'b0;
    tick();
    tick();
    #1;
    n_checks++;
    if (q !== 4'h3 || busy !== 1'b1) begin
      n_fail++; $display("FAIL mid_run_pre q busy actual=%h %b required=3 1", q, busy);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    n_checks++;
    if (q !== 4'h0 || q_bar !== 4'hF || {cmd_ready, busy, tc, done} !== 4'b1000 || passes_left !== 4'h0) begin
      n_fail++; $display("FAIL mid_run_reset q qb flags left actual=%h %h %b %h required=0 f 1000 0", q, q_bar, {cmd_ready, busy, tc, done}, passes_left);
    end
  endtask

  initial begin
    reset      = 1'b1;
    cmd_valid  = 1'b0;
    cmd_load   = 4'h0;
    cmd_term   = 4'h0;
    cmd_reload = 1'b0;
    cmd_repeat = 4'h0;
    pause      = 1'b0;
    abort      = 1'b0;
    test_reset();
    test_passes();
    tick();
    test_pause_abort();
    test_busy_handshake();
    tick();
    test_reset_mid_run();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
